// File: rtl/lcd_line_packer.sv
// Memory-LCD line packer: packs a 1-bpp pixel stream into bytes and frames each frame as
// mode byte, then per line {address, data bytes, dummy}, then a trailer, pushed into the
// line FIFO under its full flag.
module lcd_line_packer #(
    parameter int unsigned H_PIXELS = 128,
    parameter int unsigned V_LINES  = 128,
    parameter logic [7:0]  MODE_CMD = 8'h80
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_start,
    input  logic       i_vcom,
    input  logic       i_pix,
    input  logic       i_pix_valid,
    output logic       o_pix_ready,
    input  logic       i_wfull,
    output logic       o_winc,
    output logic [7:0] o_wdata,
    output logic       o_busy,
    output logic [7:0] o_line
);

    localparam int unsigned BytesPerLine = H_PIXELS / 8;
    localparam int unsigned ByteCntW     = $clog2(BytesPerLine + 1);
    localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(BytesPerLine - 1);
    localparam logic [7:0]          LastLine = 8'(V_LINES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StMode,
        StAddr,
        StData,
        StLdum,
        StTrail
    } state_e;

    state_e                state_q, state_d;
    logic                  vcom_q, vcom_d;
    logic [7:0]            line_q, line_d;
    logic [ByteCntW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;

    logic       pending;
    logic       pix_ready;
    logic       write;
    logic [7:0] byte_out;
    logic [7:0] line_inc;
    logic [7:0] addr_rev;

    // Line address is 1-based and sent LSB first, so reverse it before it hits the MSB-first
    // serializer.
    always_comb begin
        line_inc = line_q + 8'd1;
        addr_rev = 8'h00;
        for (int i = 0; i < 8; i++) begin
            addr_rev[i] = line_inc[7-i];
        end
    end

    // Decode the pending byte and pixel acceptance from the current state.
    always_comb begin
        pending   = 1'b0;
        pix_ready = 1'b0;
        byte_out  = 8'h00;
        unique case (state_q)
            StIdle: ;
            StMode: begin
                pending  = 1'b1;
                byte_out = {MODE_CMD[7], vcom_q, MODE_CMD[5:0]};
            end
            StAddr: begin
                pending  = 1'b1;
                byte_out = addr_rev;
            end
            StData: begin
                byte_out = shift_q;
                // A full byte blocks further pixels until it has been written.
                if (bit_cnt_q == 4'd8) begin
                    pending = 1'b1;
                end else begin
                    pix_ready = 1'b1;
                end
            end
            StLdum, StTrail: pending = 1'b1;
            default: ;
        endcase
        write = pending && !i_wfull && !i_rst;
    end

    // Outputs are forced quiet during a reset cycle even before the state register clears.
    always_comb begin
        o_winc      = write;
        o_pix_ready = pix_ready && !i_rst;
        o_wdata     = i_rst ? 8'h00 : byte_out;
        o_busy      = !i_rst && (state_q != StIdle);
        o_line      = i_rst ? 8'h00 : line_q;
    end

    // Next-state and counter updates; every state holds while its byte cannot be written.
    always_comb begin
        state_d    = state_q;
        vcom_d     = vcom_q;
        line_d     = line_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        unique case (state_q)
            StIdle: begin
                if (i_frame_start) begin
                    vcom_d  = i_vcom;
                    line_d  = 8'd0;
                    state_d = StMode;
                end
            end
            StMode: begin
                if (write) state_d = StAddr;
            end
            StAddr: begin
                if (write) begin
                    byte_cnt_d = '0;
                    bit_cnt_d  = 4'd0;
                    state_d    = StData;
                end
            end
            StData: begin
                if (pix_ready && i_pix_valid) begin
                    shift_d   = {shift_q[6:0], i_pix};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (write) begin
                    bit_cnt_d  = 4'd0;
                    byte_cnt_d = byte_cnt_q + ByteCntW'(1);
                    if (byte_cnt_q == LastByte) state_d = StLdum;
                end
            end
            StLdum: begin
                if (write) begin
                    if (line_q == LastLine) begin
                        state_d = StTrail;
                    end else begin
                        line_d  = line_inc;
                        state_d = StAddr;
                    end
                end
            end
            StTrail: begin
                if (write) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            vcom_q     <= 1'b0;
            line_q     <= 8'd0;
            byte_cnt_q <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            vcom_q     <= vcom_d;
            line_q     <= line_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: tb/tb_lcd_line_packer.sv
// Scoreboard bench for lcd_line_packer: one 16x2 instance and one 8x1 instance sharing stimulus,
// selected by sel; expected bytes are queued when a frame's pixels are generated.
module tb_lcd_line_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, frame_start, vcom, pix, pix_valid, wfull, sel;
    logic       ready0, winc0, busy0, ready1, winc1, busy1;
    logic [7:0] wdata0, line0, wdata1, line1;
    logic       ready_m, winc_m, busy_m;
    logic [7:0] wdata_m, line_m;

    lcd_line_packer #(.H_PIXELS(16), .V_LINES(2), .MODE_CMD(8'h80)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start & ~sel), .i_vcom(vcom),
        .i_pix(pix), .i_pix_valid(pix_valid), .o_pix_ready(ready0), .i_wfull(wfull),
        .o_winc(winc0), .o_wdata(wdata0), .o_busy(busy0), .o_line(line0)
    );

    lcd_line_packer #(.H_PIXELS(8), .V_LINES(1), .MODE_CMD(8'h80)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start & sel), .i_vcom(vcom),
        .i_pix(pix), .i_pix_valid(pix_valid), .o_pix_ready(ready1), .i_wfull(wfull),
        .o_winc(winc1), .o_wdata(wdata1), .o_busy(busy1), .o_line(line1)
    );

    assign ready_m = sel ? ready1 : ready0;
    assign winc_m  = sel ? winc1  : winc0;
    assign busy_m  = sel ? busy1  : busy0;
    assign wdata_m = sel ? wdata1 : wdata0;
    assign line_m  = sel ? line1  : line0;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int         kind_q[$];   // 0 mode, 1 addr, 2 data, 3 dummy, 4 trailer
    bit         pix_mem[256];
    int         h_cur, v_cur;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Generate the frame's pixels and queue the byte sequence the LCD must receive.
    task automatic build_frame(input bit v, input int pat);
        logic [7:0] la, rv, d;
        exp_q.delete();
        kind_q.delete();
        for (int i = 0; i < h_cur * v_cur; i++) begin
            pix_mem[i] = (pat == 0) ? ((i % 2) == 0) : 1'($urandom_range(0, 1));
        end
        exp_q.push_back({1'b1, v, 6'b000000});
        kind_q.push_back(0);
        for (int l = 0; l < v_cur; l++) begin
            la = 8'(l + 1);
            for (int k = 0; k < 8; k++) rv[k] = la[7-k];
            exp_q.push_back(rv);
            kind_q.push_back(1);
            for (int b = 0; b < h_cur / 8; b++) begin
                d = 8'h00;
                for (int k = 0; k < 8; k++) d = {d[6:0], pix_mem[l*h_cur + b*8 + k]};
                exp_q.push_back(d);
                kind_q.push_back(2);
            end
            exp_q.push_back(8'h00);
            kind_q.push_back(3);
        end
        exp_q.push_back(8'h00);
        kind_q.push_back(4);
    endtask

    // vmode: 0 valid always, 1 valid every other cycle, 2 random valid and random full.
    task automatic run_frame(input bit v, input int vmode, input int pat, input bit stall,
                             input bit restart, input bit abort);
        int         pidx, bits, line_e, nbytes, exp_total, stall_left, post, kind;
        bit         stalled, done, pend;
        logic [7:0] held;
        pidx = 0; bits = 0; line_e = 0; nbytes = 0; stall_left = 0; post = 0;
        stalled = 0; done = 0; held = 8'h00;
        build_frame(v, pat);
        exp_total = exp_q.size();

        @(posedge clk); #1;
        vcom = v; frame_start = 1'b1; pix_valid = 1'b0; wfull = 1'b0;
        #1;
        chk("idle_busy", busy_m, 0);
        chk("idle_ready", ready_m, 0);
        @(posedge clk); #1;
        frame_start = 1'b0;
        vcom = ~v;

        for (int cyc = 0; cyc < 3000 && post < 3; cyc++) begin
            kind = (kind_q.size() > 0) ? kind_q[0] : -1;
            pend = (kind >= 0) && (kind != 2 || bits == 8);
            if (stall && !stalled && kind == 2 && bits == 8) begin
                stalled = 1; stall_left = 5; held = wdata_m;
            end
            if (stall_left > 0)  wfull = 1'b1;
            else if (vmode == 2) wfull = ($urandom_range(0, 3) == 0);
            else                 wfull = 1'b0;
            pix_valid   = (vmode == 0) ? 1'b1 :
                          (vmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            pix         = (pidx < h_cur * v_cur) ? pix_mem[pidx] : 1'b0;
            frame_start = restart && (cyc == 15);
            if (abort && line_e == 1 && kind == 2 && bits == 3) begin
                rst = 1'b1;
                #1;
                chk("rst_cycle_winc", winc_m, 0);
                chk("rst_cycle_ready", ready_m, 0);
                @(posedge clk); #1;
                rst = 1'b0; pix_valid = 1'b0; wfull = 1'b0;
                #1;
                chk("after_rst_busy", busy_m, 0);
                chk("after_rst_winc", winc_m, 0);
                chk("after_rst_line", line_m, 0);
                exp_q.delete();
                kind_q.delete();
                return;
            end
            #1;
            chk("ready", ready_m, (kind == 2 && bits < 8));
            chk("winc", winc_m, (pend && !wfull));
            chk("busy", busy_m, (kind >= 0));
            chk("line", line_m, line_e);
            if (stall_left > 0) begin
                chk("stall_hold", wdata_m, held);
                stall_left--;
            end
            if (winc_m) begin
                if (exp_q.size() == 0) begin
                    chk("extra_write", winc_m, 0);
                end else begin
                    chk("wdata", wdata_m, exp_q.pop_front());
                    kind = kind_q.pop_front();
                    nbytes++;
                    if (kind == 2) bits = 0;
                    if (kind == 3 && line_e < v_cur - 1) line_e++;
                    if (kind == 4) done = 1;
                end
            end
            if (pix_valid && ready_m) begin
                bits++;
                pidx++;
            end
            if (done) post++;
            @(posedge clk); #1;
        end
        frame_start = 1'b0; pix_valid = 1'b0; wfull = 1'b0;
        chk("frame_done", done, 1);
        chk("frame_bytes", nbytes, exp_total);
        if (stall) chk("stall_seen", stalled, 1);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; vcom = 1'b0; pix = 1'b0; pix_valid = 1'b0;
        wfull = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("reset_winc", winc_m, 0);
            chk("reset_ready", ready_m, 0);
            chk("reset_busy", busy_m, 0);
            chk("reset_wdata", wdata_m, 0);
            chk("reset_line", line_m, 0);
        end

        sel = 1'b0; h_cur = 16; v_cur = 2;
        run_frame(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);   // C0 80 AA AA 00 40 AA AA 00 00
        run_frame(1'b1, 0, 0, 1'b1, 1'b0, 1'b0);   // full held over a pending data byte
        run_frame(1'b0, 1, 1, 1'b0, 1'b0, 1'b0);   // valid toggling
        run_frame(1'b1, 0, 1, 1'b0, 1'b1, 1'b0);   // second start mid-frame ignored
        run_frame(1'b1, 0, 1, 1'b0, 1'b0, 1'b1);   // reset during line 1 data
        run_frame(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);   // fresh frame after reset
        run_frame(1'b0, 2, 1, 1'b0, 1'b0, 1'b0);   // random valid and full

        sel = 1'b1; h_cur = 8; v_cur = 1;
        run_frame(1'b0, 0, 1, 1'b0, 1'b0, 1'b0);   // 80 80 <byte> 00 00
        run_frame(1'b1, 2, 1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
